snake_game_ctrl: RTL



---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_game_ctrl_if.sv | 37 +++
 rtl/snake_game_ctrl_btn_sync_edge.sv | 27 ++
 rtl/snake_game_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller and renderer:
// direction codes, game-state encoding and the opposite-direction helper.
package snake_pkg;

    localparam logic [2:0] DIR_IDLE  = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b010;
    localparam logic [2:0] DIR_LEFT  = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b100;

    localparam logic [1:0] GS_IDLE      = 2'b00;
    localparam logic [1:0] GS_PLAY      = 2'b01;
    localparam logic [1:0] GS_GAME_OVER = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = GS_IDLE,
        ST_PLAY      = GS_PLAY,
        ST_GAME_OVER = GS_GAME_OVER
    } game_state_t;

    // Direction that would reverse the snake onto itself; IDLE has none.
    function automatic logic [2:0] opposite(input logic [2:0] dir);
        case (dir)
            DIR_UP:    opposite = DIR_DOWN;
            DIR_DOWN:  opposite = DIR_UP;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_RIGHT: opposite = DIR_LEFT;
            default:   opposite = DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Bundle between the game controller and its surroundings (sync generator,
// buttons, renderers). The controller side is the master modport.
//
// Protocol: there is no back-pressure. update and eat are one-cycle strobes
// that the renderer must accept in the cycle they are high; direction,
// game_state and score are level signals valid every cycle.
interface snake_game_ctrl_if #(
    parameter int BIT     = 10,
    parameter int SCORE_W = 8
);
    logic [BIT-1:0]     x_pos;
    logic [BIT-1:0]     y_pos;
    logic               btn_up;
    logic               btn_down;
    logic               btn_left;
    logic               btn_right;
    logic               snake_head_active;
    logic               snake_body_active;
    logic               food_active;
    logic [2:0]         direction;
    logic               update;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic               eat;

    modport master (
        input  x_pos, y_pos, btn_up, btn_down, btn_left, btn_right,
        input  snake_head_active, snake_body_active, food_active,
        output direction, update, game_state, score, eat
    );

    modport slave (
        output x_pos, y_pos, btn_up, btn_down, btn_left, btn_right,
        output snake_head_active, snake_body_active, food_active,
        input  direction, update, game_state, score, eat
    );
endinterface

// File: rtl/snake_game_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus rising-edge detect.
// press is high for one cycle after the synchronized level goes 0->1.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic meta;
    logic sync;
    logic sync_prev;

    // Synchronizer chain and the previous-level register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            meta      <= btn;
            sync      <= meta;
            sync_prev <= sync;
        end
    end

    assign press = sync & ~sync_prev;
endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: turns button presses into a pending direction,
// watches the renderer's pixel flags during the visible scan, and once per
// step issues the update strobe, scores food and detects collisions.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int BIT              = 10,
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int FRAMES_PER_STEP  = 8,
    parameter int GAME_OVER_FRAMES = 60,
    parameter int SCORE_W          = 8
) (
    input logic                clk,
    input logic                reset,
    snake_game_ctrl_if.master  bus
);
    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int GO_W   = (GAME_OVER_FRAMES > 1) ? $clog2(GAME_OVER_FRAMES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [GO_W-1:0]   GO_LAST   = GO_W'(GAME_OVER_FRAMES - 1);

    logic press_up, press_down, press_left, press_right;
    logic any_press;
    logic [2:0] press_dir;

    logic at_vblank, vblank_q, frame_tick, visible;
    logic head_seen, hit, ate;

    game_state_t        state;
    logic [2:0]         direction;
    logic [2:0]         last_dir;
    logic [SCORE_W-1:0] score;
    logic               update;
    logic               eat;
    logic               armed;
    logic [STEP_W-1:0]  step_cnt;
    logic [GO_W-1:0]    go_cnt;
    logic               crash;
    logic               commit;
    logic [2:0]         guard_dir;

    btn_sync_edge u_sync_up    (.clk(clk), .reset(reset), .btn(bus.btn_up),    .press(press_up));
    btn_sync_edge u_sync_down  (.clk(clk), .reset(reset), .btn(bus.btn_down),  .press(press_down));
    btn_sync_edge u_sync_left  (.clk(clk), .reset(reset), .btn(bus.btn_left),  .press(press_left));
    btn_sync_edge u_sync_right (.clk(clk), .reset(reset), .btn(bus.btn_right), .press(press_right));

    // Pick one press per cycle, UP first, RIGHT last.
    always_comb begin
        press_dir = DIR_IDLE;
        if (press_up)         press_dir = DIR_UP;
        else if (press_down)  press_dir = DIR_DOWN;
        else if (press_left)  press_dir = DIR_LEFT;
        else if (press_right) press_dir = DIR_RIGHT;
        any_press = press_up | press_down | press_left | press_right;
    end

    assign at_vblank  = (bus.x_pos == '0) && (bus.y_pos == BIT'(V_ACTIVE));
    assign frame_tick = at_vblank & ~vblank_q;
    assign visible    = (bus.x_pos < BIT'(H_ACTIVE)) && (bus.y_pos < BIT'(V_ACTIVE));

    // A press is checked against the direction that will be committed after
    // this cycle, so a press landing on a committing tick cannot reverse.
    assign crash     = armed & (hit | ~head_seen);
    assign commit    = (state == ST_PLAY) & frame_tick & ~crash & (step_cnt == STEP_LAST);
    assign guard_dir = commit ? direction : last_dir;

    // Remember the vblank condition so the frame tick fires only once.
    always_ff @(posedge clk) begin
        if (reset) vblank_q <= 1'b0;
        else       vblank_q <= at_vblank;
    end

    // Accumulate renderer flags over the visible area; cleared on each tick.
    always_ff @(posedge clk) begin
        if (reset || frame_tick) begin
            head_seen <= 1'b0;
            hit       <= 1'b0;
            ate       <= 1'b0;
        end else if (visible) begin
            head_seen <= head_seen | bus.snake_head_active;
            hit       <= hit | (bus.snake_head_active & bus.snake_body_active);
            ate       <= ate | (bus.snake_head_active & bus.food_active);
        end
    end

    // Game FSM with registered direction, strobes, score and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            direction <= DIR_IDLE;
            last_dir  <= DIR_IDLE;
            score     <= '0;
            update    <= 1'b0;
            eat       <= 1'b0;
            armed     <= 1'b0;
            step_cnt  <= '0;
            go_cnt    <= '0;
        end else begin
            update <= 1'b0;
            eat    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    direction <= DIR_IDLE;
                    if (any_press) begin
                        state     <= ST_PLAY;
                        direction <= press_dir;
                        last_dir  <= press_dir;
                        score     <= '0;
                        armed     <= 1'b0;
                        step_cnt  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (any_press && (press_dir != opposite(guard_dir))) begin
                        direction <= press_dir;
                    end
                    if (frame_tick) begin
                        armed <= 1'b1;
                        if (crash) begin
                            state     <= ST_GAME_OVER;
                            direction <= DIR_IDLE;
                            go_cnt    <= '0;
                        end else if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            update   <= 1'b1;
                            last_dir <= direction;
                            if (ate) begin
                                eat <= 1'b1;
                                if (score != '1) score <= score + 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    direction <= DIR_IDLE;
                    if (frame_tick) begin
                        if (go_cnt == GO_LAST) state <= ST_IDLE;
                        else                   go_cnt <= go_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.direction  = direction;
    assign bus.update     = update;
    assign bus.game_state = state;
    assign bus.score      = score;
    assign bus.eat        = eat;
endmodule
